// File: rtl/sinal_de_controle_if.sv
// sinal_de_controle_if
//   Bundle between instruction fetch/decode and the main control unit.
//   The master side (fetch/decode) drives OpCode and receives the
//   registered datapath controls. The slave side (control unit) samples
//   OpCode and drives the controls.
//
//   Signals:
//     OpCode    4-bit instruction opcode (master -> slave)
//     Halt      processor halt request
//     RegFonte  write-back source: 0 = ALU result, 1 = memory data
//     RegDst    destination field: 0 = rt, 1 = rd
//     EscReg    register-file write enable
//     ULA1      ALU operand A: 0 = rs, 1 = shift amount
//     ULA2      ALU operand B: 0 = rt, 1 = sign-extended immediate
//     Beq       branch-if-equal enable
//     ULAOp     4-bit ALU operation code
//     Salto     unconditional jump
//     Set       write ALU less-than flag instead of ALU result
//     LerMem    data-memory read strobe
//     EscMem    data-memory write strobe
interface sinal_de_controle_if;
  logic [3:0] OpCode;
  logic       Halt;
  logic       RegFonte;
  logic       RegDst;
  logic       EscReg;
  logic       ULA1;
  logic       ULA2;
  logic       Beq;
  logic [3:0] ULAOp;
  logic       Salto;
  logic       Set;
  logic       LerMem;
  logic       EscMem;

  modport master (
    output OpCode,
    input  Halt, RegFonte, RegDst, EscReg, ULA1, ULA2, Beq, ULAOp,
           Salto, Set, LerMem, EscMem
  );

  modport slave (
    input  OpCode,
    output Halt, RegFonte, RegDst, EscReg, ULA1, ULA2, Beq, ULAOp,
           Salto, Set, LerMem, EscMem
  );
endinterface

// File: rtl/sinal_de_controle.sv
// sinal_de_controle
//   Main control unit of the single-issue processor. Decodes the 4-bit
//   opcode into datapath controls and registers them, so the datapath sees
//   the controls one clock after the opcode is sampled.
//
//   Ports:
//     clock    system clock, rising-edge active
//     reset_n  asynchronous active-low reset; clears every control at once
//     ctrl     sinal_de_controle_if.slave: OpCode in, registered controls out
//
//   Configuration macro:
//     SDC_STICKY_HALT_EN  when defined, HALT (1111) is sticky: once sampled,
//                         Halt stays high and every other control stays low
//                         until reset_n asserts. When undefined, Halt is a
//                         plain one-cycle decode.
module sinal_de_controle (
  input  logic             clock,
  input  logic             reset_n,
  sinal_de_controle_if.slave ctrl
);

  typedef struct packed {
    logic       halt;
    logic       reg_fonte;
    logic       reg_dst;
    logic       esc_reg;
    logic       ula1;
    logic       ula2;
    logic       beq;
    logic [3:0] ula_op;
    logic       salto;
    logic       set;
    logic       ler_mem;
    logic       esc_mem;
  } ctrl_t;

  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0001;
  localparam logic [3:0] ULA_AND = 4'b0010;
  localparam logic [3:0] ULA_OR  = 4'b0011;
  localparam logic [3:0] ULA_SLL = 4'b0100;
  localparam logic [3:0] ULA_SRL = 4'b0101;

  ctrl_t decoded;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Opcode decode. Reserved codes and any X/Z opcode fall into the default
  // branch and leave every control at 0.
  always_comb begin
    decoded = '0;
    case (ctrl.OpCode)
      4'b0000: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula_op  = ULA_ADD;
      end
      4'b0001: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula_op  = ULA_SUB;
      end
      4'b0010: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula_op  = ULA_AND;
      end
      4'b0011: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula_op  = ULA_OR;
      end
      4'b0100: begin
        // SLT subtracts and writes the sign flag instead of the result.
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.set     = 1'b1;
        decoded.ula_op  = ULA_SUB;
      end
      4'b0101: begin
        decoded.esc_reg = 1'b1;
        decoded.ula2    = 1'b1;
        decoded.ula_op  = ULA_ADD;
      end
      4'b0110: begin
        decoded.esc_reg   = 1'b1;
        decoded.reg_fonte = 1'b1;
        decoded.ler_mem   = 1'b1;
        decoded.ula2      = 1'b1;
        decoded.ula_op    = ULA_ADD;
      end
      4'b0111: begin
        decoded.esc_mem = 1'b1;
        decoded.ula2    = 1'b1;
        decoded.ula_op  = ULA_ADD;
      end
      4'b1000: begin
        decoded.beq    = 1'b1;
        decoded.ula_op = ULA_SUB;
      end
      4'b1001: begin
        decoded.salto = 1'b1;
      end
      4'b1010: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula1    = 1'b1;
        decoded.ula_op  = ULA_SLL;
      end
      4'b1011: begin
        decoded.reg_dst = 1'b1;
        decoded.esc_reg = 1'b1;
        decoded.ula1    = 1'b1;
        decoded.ula_op  = ULA_SRL;
      end
      4'b1111: begin
        decoded.halt = 1'b1;
      end
      default: begin
        decoded = '0;
      end
    endcase
  end

`ifdef SDC_STICKY_HALT_EN
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Once halted, only reset leaves HALTED; the opcode is ignored and the
  // registered controls are pinned to "Halt only".
  always_comb begin
    state_d = state_q;
    ctrl_d  = decoded;
    case (state_q)
      RUN: begin
        if (decoded.halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        ctrl_d      = '0;
        ctrl_d.halt = 1'b1;
      end
    endcase
  end
`else
  always_comb begin
    ctrl_d = decoded;
  end
`endif

  // Output register; reset clears all controls without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl.Halt     = ctrl_q.halt;
  assign ctrl.RegFonte = ctrl_q.reg_fonte;
  assign ctrl.RegDst   = ctrl_q.reg_dst;
  assign ctrl.EscReg   = ctrl_q.esc_reg;
  assign ctrl.ULA1     = ctrl_q.ula1;
  assign ctrl.ULA2     = ctrl_q.ula2;
  assign ctrl.Beq      = ctrl_q.beq;
  assign ctrl.ULAOp    = ctrl_q.ula_op;
  assign ctrl.Salto    = ctrl_q.salto;
  assign ctrl.Set      = ctrl_q.set;
  assign ctrl.LerMem   = ctrl_q.ler_mem;
  assign ctrl.EscMem   = ctrl_q.esc_mem;

endmodule

// File: tb/tb_sinal_de_controle.sv
// tb_sinal_de_controle
//   Bench for the main control unit. A reference model built from the
//   instruction table (plus a halted flag when SDC_STICKY_HALT_EN is
//   defined) predicts the control word after each rising edge.
//   Control word layout used here:
//   {Halt, RegFonte, RegDst, EscReg, ULA1, ULA2, Beq, ULAOp[3:0],
//    Salto, Set, LerMem, EscMem}
module tb_sinal_de_controle;

  logic clock;
  logic reset_n;

  sinal_de_controle_if ctrl_if ();

  sinal_de_controle dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctrl    (ctrl_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit sticky   = 1'b0;
  bit halted   = 1'b0;

  localparam logic [14:0] HALT_ONLY = 15'b100_0000_0000_0000;

  // Clock with a 10-time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected control word for one opcode, straight from the instruction table.
  function automatic logic [14:0] expected_for(input logic [3:0] op);
    logic       halt, fonte, dst, wr, a1, a2, beq, jmp, setf, rd, wm;
    logic [3:0] alu;
    {halt, fonte, dst, wr, a1, a2, beq, jmp, setf, rd, wm} = '0;
    alu = 4'd0;
    case (op)
      4'd0:  begin dst = 1; wr = 1; alu = 4'd0; end
      4'd1:  begin dst = 1; wr = 1; alu = 4'd1; end
      4'd2:  begin dst = 1; wr = 1; alu = 4'd2; end
      4'd3:  begin dst = 1; wr = 1; alu = 4'd3; end
      4'd4:  begin dst = 1; wr = 1; setf = 1; alu = 4'd1; end
      4'd5:  begin wr = 1; a2 = 1; alu = 4'd0; end
      4'd6:  begin wr = 1; fonte = 1; rd = 1; a2 = 1; alu = 4'd0; end
      4'd7:  begin wm = 1; a2 = 1; alu = 4'd0; end
      4'd8:  begin beq = 1; alu = 4'd1; end
      4'd9:  begin jmp = 1; end
      4'd10: begin dst = 1; wr = 1; a1 = 1; alu = 4'd4; end
      4'd11: begin dst = 1; wr = 1; a1 = 1; alu = 4'd5; end
      4'd15: begin halt = 1; end
      default: ;
    endcase
    return {halt, fonte, dst, wr, a1, a2, beq, alu, jmp, setf, rd, wm};
  endfunction

  function automatic logic [14:0] observed();
    return {ctrl_if.Halt, ctrl_if.RegFonte, ctrl_if.RegDst, ctrl_if.EscReg,
            ctrl_if.ULA1, ctrl_if.ULA2, ctrl_if.Beq, ctrl_if.ULAOp,
            ctrl_if.Salto, ctrl_if.Set, ctrl_if.LerMem, ctrl_if.EscMem};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [14:0] obs,
                             input logic [14:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Present op on the falling edge, let the rising edge sample it, then
  // compare and scramble OpCode between edges.
  task automatic applyStimulus(input logic [3:0] op, input string tag);
    logic [14:0] exp;
    @(negedge clock);
    ctrl_if.OpCode = op;
    @(posedge clock);
    #1;
    exp    = halted ? HALT_ONLY : expected_for(op);
    halted = sticky && (halted || op == 4'd15);
    checkOutput($sformatf("%s op=%0d", tag, op), observed(), exp);
    ctrl_if.OpCode = 4'($urandom);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulseReset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(tag, observed(), 15'd0);
    reset_n = 1'b1;
    halted  = 1'b0;
  endtask

  initial begin
`ifdef SDC_STICKY_HALT_EN
    sticky = 1'b1;
`endif
    reset_n        = 1'b0;
    ctrl_if.OpCode = 4'b0110;

    // Reset held across edges keeps everything low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("reset_hold", observed(), 15'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("first_decode_lw", observed(), expected_for(4'b0110));

    // Sweep the defined non-halt opcodes.
    for (int op = 0; op < 12; op++) begin
      applyStimulus(4'(op), "sweep");
    end

    applyStimulus(4'd7, "store");
    applyStimulus(4'd8, "branch");
    applyStimulus(4'd9, "jump");

    for (int op = 12; op < 15; op++) begin
      applyStimulus(4'(op), "reserved");
    end

    // Halt then asynchronous reset while Halt is high.
    applyStimulus(4'd15, "halt");
    pulseReset("async_reset_halt");

    // Halt followed by ADD: sticky or plain depending on configuration.
    applyStimulus(4'd15, "halt2");
    applyStimulus(4'd0, "after_halt");
    applyStimulus(4'd3, "after_halt2");
    pulseReset("async_reset_2");

    // Randomized opcodes with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), "rand");
      if ((halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 40) == 0) begin
        pulseReset("rand_reset");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
